// File: rtl/dbg_uart_bridge.sv
// dbg_uart_bridge: UART byte-command bridge to the 16-bit bus with rate-limited replies.
// Defining DBG_UART_AUTOINC_EN makes ADDR advance after every bus access.
module dbg_uart_bridge #(
   parameter int TX_GAP     = 4340,
   parameter int ACC_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dix,
   input  logic [7:0]  id,
   output logic        dox,
   output logic [7:0]  od,
   output logic        csu,
   output logic [15:0] addru,
   output logic        ru,
   output logic [1:0]  wru,
   input  logic [15:0] din,
   output logic [15:0] datau,
   input  logic [7:0]  status
);
   localparam int GW = $clog2(TX_GAP + 1);
   localparam int AW = $clog2(ACC_CYCLES + 1);
   typedef enum logic {S_IDLE, S_ACC} state_t;
   state_t        state_q;
   logic [AW-1:0] acc_q;
   logic [7:0]    ib_q, tb0_q, tb1_q, od_q;
   logic          ibv_q, hold_q, ru_q, dox_q;
   logic [1:0]    wru_q, tcnt_q;
   logic [15:0]   sr_q, addr_q, datau_q;
   logic [GW-1:0] gap_q;
   logic          exec_d, end_d, rd_end_d, st_d, emit_d;
   logic [7:0]    q0_d, q1_d;
   logic [1:0]    qn_d;
   always_comb begin
      exec_d   = ibv_q && state_q == S_IDLE;
      end_d    = state_q == S_ACC && acc_q == AW'(1);
      rd_end_d = end_d && ru_q;
      st_d     = exec_d && ib_q == 8'h24 && tcnt_q == 2'd0;
      // reply bytes are only ever produced while the buffer is empty
      q0_d     = tcnt_q != 2'd0 ? tb0_q : rd_end_d ? din[15:8] : status;
      q1_d     = tcnt_q != 2'd0 ? tb1_q : din[7:0];
      qn_d     = tcnt_q != 2'd0 ? tcnt_q : rd_end_d ? 2'd2 : st_d ? 2'd1 : 2'd0;
      emit_d   = qn_d != 2'd0 && gap_q == GW'(0);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         ib_q    <= '0;
         ibv_q   <= 1'b0;
         sr_q    <= '0;
         addr_q  <= '0;
         datau_q <= '0;
         hold_q  <= 1'b0;
         ru_q    <= 1'b0;
         wru_q   <= '0;
         tb0_q   <= '0;
         tb1_q   <= '0;
         tcnt_q  <= '0;
         gap_q   <= '0;
         dox_q   <= 1'b0;
         od_q    <= '0;
      end else begin
         if (dix) ib_q <= id;
         ibv_q <= dix || (ibv_q && !exec_d);
         if (state_q == S_ACC) acc_q <= acc_q - AW'(1);
         if (end_d) begin
            state_q <= S_IDLE;
            ru_q    <= 1'b0;
            wru_q   <= 2'b00;
`ifdef DBG_UART_AUTOINC_EN
            addr_q  <= addr_q + ((ru_q || wru_q == 2'b11) ? 16'd2 : 16'd1);
`endif
         end
         if (exec_d) begin
            if (ib_q[7:4] == 4'h1) sr_q <= {sr_q[11:0], ib_q[3:0]};
            if (ib_q == 8'h20) addr_q <= sr_q;
            if (ib_q == 8'h21 || ib_q == 8'h22 || (ib_q == 8'h23 && tcnt_q == 2'd0)) begin
               state_q <= S_ACC;
               acc_q   <= AW'(ACC_CYCLES);
            end
            if (ib_q == 8'h21) begin
               datau_q <= sr_q;
               wru_q   <= 2'b11;
            end
            if (ib_q == 8'h22) begin
               datau_q <= {2{sr_q[7:0]}};
               wru_q   <= addr_q[0] ? 2'b01 : 2'b10;
            end
            if (ib_q == 8'h23 && tcnt_q == 2'd0) ru_q <= 1'b1;
            if (ib_q[7:1] == 7'h18) hold_q <= ib_q[0];
         end
         dox_q  <= emit_d;
         if (emit_d) od_q <= q0_d;
         tb0_q  <= emit_d ? q1_d : q0_d;
         tb1_q  <= q1_d;
         tcnt_q <= emit_d ? qn_d - 2'd1 : qn_d;
         gap_q  <= emit_d ? GW'(TX_GAP - 1) : gap_q != GW'(0) ? gap_q - GW'(1) : gap_q;
      end
   end
   assign csu   = hold_q || state_q == S_ACC;
   assign addru = addr_q;
   assign ru    = ru_q;
   assign wru   = wru_q;
   assign datau = datau_q;
   assign dox   = dox_q;
   assign od    = od_q;
endmodule

// File: tb/tb_dbg_uart_bridge.sv
// tb_dbg_uart_bridge: directed plus randomized command streams checked against a timestamped reference model.
module tb_dbg_uart_bridge;
   localparam int G = 4;
   localparam int A = 2;
   logic        clk = 1'b0, reset = 1'b1, dix = 1'b0;
   logic [7:0]  id = '0, status = '0, od;
   logic        dox, csu, ru;
   logic [15:0] addru, datau, din = '0;
   logic [1:0]  wru;
   int vec = 0, errs = 0;
   dbg_uart_bridge #(.TX_GAP(G), .ACC_CYCLES(A)) dut (
      .clk(clk), .reset(reset), .dix(dix), .id(id), .dox(dox), .od(od), .csu(csu),
      .addru(addru), .ru(ru), .wru(wru), .din(din), .datau(datau), .status(status)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   // model: accesses are cycle windows [acc_s, acc_e]; replies are a byte queue released no sooner than next_tx
   int t = 0, acc_s = -10, acc_e = -10, pr = 0, next_tx = 0;
   logic [15:0] m_sr, m_addr, m_datau;
   logic        m_hold, m_rd, pv, e_dox;
   logic [1:0]  m_wru;
   logic [7:0]  pb, e_od;
   logic [7:0]  tq[$];
   bit ina;
   always @(negedge clk) begin
      t++;
      if (reset) begin
         m_sr = 0; m_addr = 0; m_datau = 0; m_hold = 0; m_rd = 0; m_wru = 0;
         pv = 0; e_dox = 0; e_od = 0; tq.delete(); acc_s = -10; acc_e = -10; next_tx = 0;
      end
      ina = t >= acc_s && t <= acc_e;
      chk("csu", 16'(csu), 16'(m_hold | ina));
      chk("ru", 16'(ru), 16'(ina & m_rd));
      chk("wru", 16'(wru), 16'(ina ? m_wru : 2'b00));
      chk("addru", addru, m_addr);
      chk("datau", datau, m_datau);
      chk("dox", 16'(dox), 16'(e_dox));
      chk("od", 16'(od), 16'(e_od));
      if (!reset) begin
         if (acc_e == t) begin
            if (m_rd) begin
               tq.push_back(din[15:8]);
               tq.push_back(din[7:0]);
            end
`ifdef DBG_UART_AUTOINC_EN
            m_addr = m_addr + ((m_rd || m_wru == 2'b11) ? 16'd2 : 16'd1);
`endif
         end
         if (pv && pr <= t && acc_e < t) begin
            pv = 0;
            if (pb[7:4] == 4'h1) m_sr = {m_sr[11:0], pb[3:0]};
            else if (pb == 8'h20) m_addr = m_sr;
            else if (pb == 8'h21) begin
               m_datau = m_sr; m_wru = 2'b11; m_rd = 0; acc_s = t + 1; acc_e = t + A;
            end else if (pb == 8'h22) begin
               m_datau = {m_sr[7:0], m_sr[7:0]}; m_wru = m_addr[0] ? 2'b01 : 2'b10;
               m_rd = 0; acc_s = t + 1; acc_e = t + A;
            end else if (pb == 8'h23 && tq.size() == 0) begin
               m_rd = 1; m_wru = 2'b00; acc_s = t + 1; acc_e = t + A;
            end else if (pb == 8'h24 && tq.size() == 0) tq.push_back(status);
            else if (pb == 8'h30 || pb == 8'h31) m_hold = pb[0];
         end
         if (tq.size() > 0 && t + 1 >= next_tx) begin
            e_dox = 1; e_od = tq.pop_front(); next_tx = t + 1 + G;
         end else e_dox = 0;
         if (dix) begin
            pv = 1; pb = id; pr = t + 1;
         end
      end
   end
   task automatic send(input logic [7:0] b);
      @(posedge clk); #2 dix = 1'b1; id = b;
      @(posedge clk); #2 dix = 1'b0;
   endtask
   task automatic tick();
      @(posedge clk); #1;
   endtask
   function automatic logic [7:0] pick();
      int r;
      r = $urandom_range(0, 15);
      if (r < 6) return 8'h10 | 8'($urandom_range(0, 15));
      if (r == 6) return 8'h20;
      if (r < 9) return 8'h21;
      if (r == 9) return 8'h22;
      if (r < 12) return 8'h23;
      if (r == 12) return 8'h24;
      if (r == 13) return 8'h30 | 8'($urandom_range(0, 1));
      if (r == 14) return 8'($urandom);
      return 8'h1F;
   endfunction
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_csu", 16'(csu), 16'd0);
      chk("rst_dox", 16'(dox), 16'd0);
      chk("rst_addru", addru, 16'h0000);
      #1 reset = 1'b0;
      repeat (2) tick();
      send(8'h11); send(8'h12); send(8'h13); send(8'h14); send(8'h20);
      tick();
      chk("set_addr", addru, 16'h1234);
      chk("set_addr_csu", 16'(csu), 16'd0);
      send(8'h1A); send(8'h1B); send(8'h1C); send(8'h1D); send(8'h21);
      tick();
      chk("ww_csu", 16'(csu), 16'd1);
      chk("ww_wru", 16'(wru), 16'h3);
      chk("ww_datau", datau, 16'hABCD);
      chk("ww_addru", addru, 16'h1234);
      tick();
      chk("ww_csu2", 16'(csu), 16'd1);
      tick();
      chk("ww_csu_end", 16'(csu), 16'd0);
`ifdef DBG_UART_AUTOINC_EN
      chk("ww_inc", addru, 16'h1236);
`else
      chk("ww_inc", addru, 16'h1234);
`endif
      send(8'h10); send(8'h11); send(8'h10); send(8'h11); send(8'h20);
      send(8'h10); send(8'h10); send(8'h15); send(8'h15); send(8'h22);
      tick();
      chk("bw_odd_wru", 16'(wru), 16'h1);
      chk("bw_datau", datau, 16'h5555);
      send(8'h10); send(8'h11); send(8'h10); send(8'h10); send(8'h20);
      send(8'h10); send(8'h10); send(8'h15); send(8'h15); send(8'h22);
      tick();
      chk("bw_even_wru", 16'(wru), 16'h2);
      din = 16'hBEEF;
      repeat (G + 2) tick();
      send(8'h23);
      tick();
      chk("rd_ru1", 16'(ru), 16'd1);
      tick();
      chk("rd_ru2", 16'(ru), 16'd1);
      tick();
      chk("rd_ru_off", 16'(ru), 16'd0);
      chk("rd_dox1", 16'(dox), 16'd1);
      chk("rd_od1", 16'(od), 16'h00BE);
      fork send(8'h24); join_none
      for (int k = 1; k <= G; k++) begin
         tick();
         chk("rd_dox2", 16'(dox), 16'(k == G));
      end
      chk("rd_od2", 16'(od), 16'h00EF);
      for (int k = 0; k < G + 4; k++) begin
         tick();
         chk("st_ignored", 16'(dox), 16'd0);
      end
      status = 8'h25;
      send(8'h31); send(8'h24);
      tick();
      chk("hold_csu", 16'(csu), 16'd1);
      chk("st_dox", 16'(dox), 16'd1);
      chk("st_od", 16'(od), 16'h0025);
      repeat (3) tick();
      chk("hold_csu2", 16'(csu), 16'd1);
      send(8'h30);
      tick();
      chk("unhold_csu", 16'(csu), 16'd0);
      repeat (G + 2) tick();
      send(8'h23);
      tick();
      chk("mid_ru", 16'(ru), 16'd1);
      #2 reset = 1'b1;
      #1;
      chk("mr_csu", 16'(csu), 16'd0);
      chk("mr_ru", 16'(ru), 16'd0);
      chk("mr_addru", addru, 16'h0000);
      chk("mr_datau", datau, 16'h0000);
      chk("mr_od", 16'(od), 16'd0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("mr_no_dox", 16'(dox), 16'd0);
      end
      for (int c = 0; c < 6000; c++) begin
         @(posedge clk); #2;
         reset  = $urandom_range(0, 799) == 0;
         dix    = $urandom_range(0, 2) == 0;
         id     = pick();
         din    = 16'($urandom);
         status = 8'($urandom);
      end
      @(posedge clk); #2 dix = 1'b0; reset = 1'b0;
      repeat (30) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
